sample_conditioner: RTL and testbench
=====================================

SAMPLE_CONDITIONER -- requirements
Module: sample_conditioner

Interface
REQ-001 Parameter WIDTH, default 16, sets sample width in bits; samples are two's complement.
REQ-002 Parameter DC_SHIFT, default 8, sets the DC-estimator pole: 1 - 2^-DC_SHIFT.
REQ-003 Port clk_in, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 Port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port sample_in, input, WIDTH bits: signed input sample.
REQ-006 Port valid_in, input, 1 bit: sample_in is valid this cycle.
REQ-007 Port gain_in, input, 4 bits: left-shift gain 0..15, sampled on each valid_in.
REQ-008 Port bypass_in, input, 1 bit: skips DC removal and gain, sampled on each valid_in.
REQ-009 Port sample_out, output, WIDTH bits: signed conditioned sample.
REQ-010 Port sample_unsigned_out, output, WIDTH bits: sample_out with the MSB inverted (offset binary, for the PDM stage).
REQ-011 Port valid_out, output, 1 bit: one-cycle strobe marking a new sample_out.
REQ-012 Port clip_out, output, 1 bit: one-cycle strobe, coincident with valid_out, when saturation occurred.
REQ-013 Port clip_count_out, output, 16 bits: saturating count of clip events.

Function
REQ-014 The block SHALL accept valid_in on any cycle, including every cycle back-to-back, with no stall and no loss.
REQ-015 Latency SHALL be exactly 3 cycles from valid_in to valid_out; output order SHALL equal input order.
REQ-016 Stage 1: dc = acc >>> DC_SHIFT and y = x - dc (WIDTH+1 bits); acc (WIDTH+DC_SHIFT+1 bits, signed) SHALL update to acc + y on each valid_in only.
REQ-017 Stage 2: y SHALL be shifted left by the gain_in captured with that sample; the result SHALL saturate to 2^(WIDTH-1)-1 or -2^(WIDTH-1); clip is flagged when saturation changes the value.
REQ-018 Stage 3: the result SHALL be registered to sample_out, valid_out and clip_out.
REQ-019 A sample with bypass_in=1 SHALL be passed through unmodified, with the same 3-cycle latency; it SHALL still update acc, and SHALL never clip.
REQ-020 FSM states: WARMUP and RUN. Reset enters WARMUP. WARMUP counts accepted samples; the transition to RUN occurs after 2^DC_SHIFT samples. RUN is held until reset.
REQ-021 In WARMUP, non-bypass outputs SHALL be 0 with valid_out still asserted, and clip_out SHALL be 0.
REQ-022 clip_count_out SHALL hold at 0xFFFF and not wrap.
REQ-023 Between strobes, sample_out SHALL hold its last value, and valid_out and clip_out SHALL be 0.

Reset
REQ-024 While rst_in=0, all outputs, acc, the warmup counter and the pipeline valids SHALL be 0, and the state SHALL be WARMUP.
REQ-025 Reset asserted mid-pipeline SHALL discard in-flight samples; no valid_out SHALL appear for them after release.

Configuration
REQ-026 With macro SAMPLE_COND_CLIP_STATS_EN defined, clip_count_out SHALL be implemented per REQ-022.
REQ-027 Without the macro, clip_count_out SHALL be constant 0, with no counter logic; clip_out is unaffected.

Structure
REQ-028 Shared package audio_pkg SHALL hold the default WIDTH, the cond_state_t enum (WARMUP, RUN) and the saturation limit constants.
REQ-029 Sub-module sat_shifter (combinational shift plus saturate plus clip flag) SHALL implement stage 2; all other logic stays in sample_conditioner.

Verification
REQ-030 Reset: hold rst_in=0 with valid_in toggling -> all outputs 0, no valid_out.
REQ-031 DC removal: 2000 samples of +1000, gain 0, bypass 0 -> first 256 outputs 0; output then decays; last output within +/-1.
REQ-032 Saturation, after warmup with acc at 0: input 0x4000, gain 2 -> 0x7FFF, clip_out=1, count +1. Input 0xC000 -> 0x8000, clip_out=1.
REQ-033 Bypass: input -5, gain 3, bypass 1 -> sample_out 0xFFFB exactly 3 cycles later, clip_out 0, sample_unsigned_out 0x7FFB.
REQ-034 Back-to-back: valid_in high for 10 consecutive cycles with ramp 1..10 in bypass -> valid_out high 10 consecutive cycles, values 1..10, starting 3 cycles after the first input.
REQ-035 Mid-run reset: pulse rst_in low for 1 cycle while 2 samples are in flight -> no valid_out for those samples; the next 256 samples output 0 (WARMUP re-entered).

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: default sample width, conditioner FSM states and
// two's-complement saturation limits.
package audio_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic signed [DEFAULT_WIDTH-1:0] SAT_POS = 16'sh7FFF;
  localparam logic signed [DEFAULT_WIDTH-1:0] SAT_NEG = 16'sh8000;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } cond_state_t;

  // Limits for an arbitrary width, used where WIDTH is overridden.
  function automatic longint sat_pos(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_neg(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/sat_shifter.sv
// Gain stage: left-shifts a WIDTH+1 bit sample by 0..15 and saturates it to
// WIDTH bits, flagging when the saturation changed the value.
module sat_shifter
  import audio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH:0]   y,
  input  logic        [3:0]       gain,
  output logic signed [WIDTH-1:0] result,
  output logic                    clip
);

  // Wide enough for a 15-bit shift of a WIDTH+1 bit operand.
  localparam int EW = WIDTH + 16;
  localparam logic signed [EW-1:0] POS_LIM = EW'(sat_pos(WIDTH));
  localparam logic signed [EW-1:0] NEG_LIM = EW'(sat_neg(WIDTH));

  logic signed [EW-1:0] wide;

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wide   = {{15{y[WIDTH]}}, y} << gain;
    result = wide[WIDTH-1:0];
    clip   = 1'b0;
    if (wide > POS_LIM) begin
      result = POS_LIM[WIDTH-1:0];
      clip   = 1'b1;
    end else if (wide < NEG_LIM) begin
      result = NEG_LIM[WIDTH-1:0];
      clip   = 1'b1;
    end
  end

endmodule

// File: rtl/sample_conditioner.sv
// Three-stage sample conditioner: DC removal, shift gain with saturation, output
// register. Define SAMPLE_COND_CLIP_STATS_EN to build the clip event counter.
module sample_conditioner
  import audio_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DC_SHIFT = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    valid_in,
  input  logic        [3:0]       gain_in,
  input  logic                    bypass_in,
  output logic signed [WIDTH-1:0] sample_out,
  output logic        [WIDTH-1:0] sample_unsigned_out,
  output logic                    valid_out,
  output logic                    clip_out,
  output logic        [15:0]      clip_count_out
);

  localparam int AW = WIDTH + DC_SHIFT + 1;

  cond_state_t         state_q, state_d;
  logic [DC_SHIFT-1:0] warm_cnt_q, warm_cnt_d;

  logic signed [AW-1:0] acc_q;
  logic signed [WIDTH:0] x_ext, dc, y;

  logic                  s1_valid, s1_bypass, s1_warm;
  logic signed [WIDTH:0] s1_val;
  logic [3:0]            s1_gain;

  logic                    s2_valid, s2_clip, s2_clip_d;
  logic signed [WIDTH-1:0] s2_val, s2_val_d, sat_val;
  logic                    sat_clip;

  // Taking the slice of acc is the arithmetic shift truncated to WIDTH+1 bits.
  assign x_ext = {sample_in[WIDTH-1], sample_in};
  assign dc    = acc_q[DC_SHIFT +: WIDTH+1];
  assign y     = x_ext - dc;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (state_q == WARMUP && valid_in) begin
      warm_cnt_d = warm_cnt_q + 1'b1;
      if (&warm_cnt_q) state_d = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= WARMUP;
      warm_cnt_q <= '0;
      acc_q      <= '0;
      s1_valid   <= 1'b0;
      s1_val     <= '0;
      s1_gain    <= '0;
      s1_bypass  <= 1'b0;
      s1_warm    <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      s1_valid   <= valid_in;
      if (valid_in) begin
        acc_q     <= acc_q + {{DC_SHIFT{y[WIDTH]}}, y};
        s1_val    <= bypass_in ? x_ext : y;
        s1_gain   <= gain_in;
        s1_bypass <= bypass_in;
        s1_warm   <= (state_q == WARMUP);
      end
    end
  end

  sat_shifter #(.WIDTH(WIDTH)) u_sat (
    .y      (s1_val),
    .gain   (s1_gain),
    .result (sat_val),
    .clip   (sat_clip)
  );

  always_comb begin
    s2_val_d  = sat_val;
    s2_clip_d = sat_clip;
    if (s1_bypass) begin
      s2_val_d  = s1_val[WIDTH-1:0];
      s2_clip_d = 1'b0;
    end else if (s1_warm) begin
      s2_val_d  = '0;
      s2_clip_d = 1'b0;
    end
  end

  // NOTE: data registers are reset as well as the valids, because every output
  // must read 0 while reset is held.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s2_valid            <= 1'b0;
      s2_val              <= '0;
      s2_clip             <= 1'b0;
      valid_out           <= 1'b0;
      clip_out            <= 1'b0;
      sample_out          <= '0;
      sample_unsigned_out <= '0;
    end else begin
      s2_valid  <= s1_valid;
      valid_out <= s2_valid;
      clip_out  <= s2_valid & s2_clip;
      if (s1_valid) begin
        s2_val  <= s2_val_d;
        s2_clip <= s2_clip_d;
      end
      if (s2_valid) begin
        sample_out          <= s2_val;
        sample_unsigned_out <= {~s2_val[WIDTH-1], s2_val[WIDTH-2:0]};
      end
    end
  end

`ifdef SAMPLE_COND_CLIP_STATS_EN
  logic [15:0] clip_cnt_q;

  // Increments on the same edge that raises clip_out; sticks at all-ones.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      clip_cnt_q <= '0;
    end else if (s2_valid && s2_clip && clip_cnt_q != 16'hFFFF) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign clip_count_out = clip_cnt_q;
`else
  assign clip_count_out = '0;
`endif

endmodule

// File: tb/tb_sample_conditioner.sv
// Scoreboard bench for sample_conditioner: an arithmetic reference model queues
// the expected output per accepted sample and a monitor checks each valid_out.
module tb_sample_conditioner;
  import audio_pkg::*;

  localparam int W  = 16;
  localparam int DS = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [W-1:0]  sample_in;
  logic          valid_in;
  logic [3:0]    gain_in;
  logic          bypass_in;
  logic signed [W-1:0] sample_out;
  logic [W-1:0]  sample_unsigned_out;
  logic          valid_out;
  logic          clip_out;
  logic [15:0]   clip_count_out;

  sample_conditioner #(.WIDTH(W), .DC_SHIFT(DS)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .sample_in           (sample_in),
    .valid_in            (valid_in),
    .gain_in             (gain_in),
    .bypass_in           (bypass_in),
    .sample_out          (sample_out),
    .sample_unsigned_out (sample_unsigned_out),
    .valid_out           (valid_out),
    .clip_out            (clip_out),
    .clip_count_out      (clip_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] sample;
    logic        clip;
    logic [15:0] cnt;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          chk_reset = 1'b0;
  logic [15:0] last_out = '0;

  // Reference model state
  longint m_acc = 0;
  int     m_count = 0;
  int     m_clips = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint wrap(input longint v, input int bits);
    logic [63:0] t;
    t = 64'(v) << (64 - bits);
    return $signed(t) >>> (64 - bits);
  endfunction

  task automatic send(input logic [15:0] x, input logic [3:0] g, input logic b);
    exp_t   e;
    longint xs, dcv, yv, v;
    @(posedge clk_in); #1;
    sample_in = x; gain_in = g; bypass_in = b; valid_in = 1'b1;
    xs    = longint'($signed(x));
    dcv   = m_acc >>> DS;
    yv    = wrap(xs - dcv, W + 1);
    m_acc = wrap(m_acc + yv, W + DS + 1);
    e.clip = 1'b0;
    if (b) begin
      e.sample = x;
    end else if (m_count < (1 << DS)) begin
      e.sample = '0;
    end else begin
      v = yv * (longint'(1) <<< g);
      if (v > longint'(SAT_POS)) begin
        e.sample = SAT_POS; e.clip = 1'b1;
      end else if (v < longint'(SAT_NEG)) begin
        e.sample = SAT_NEG; e.clip = 1'b1;
      end else begin
        e.sample = 16'(v);
      end
    end
    if (m_count < (1 << DS)) m_count++;
    if (e.clip && m_clips != 65535) m_clips++;
`ifdef SAMPLE_COND_CLIP_STATS_EN
    e.cnt = 16'(m_clips);
`else
    e.cnt = '0;
`endif
    e.issue = cyc;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    rst_in   = 1'b0;
    sb.delete();
    m_acc = 0; m_count = 0; m_clips = 0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk_in);
    #1;
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare every strobe against the scoreboard, and check idle cycles.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      if (chk_reset) begin
        check("rst_sample_out", 32'($unsigned(sample_out)), 32'd0);
        check("rst_sample_unsigned_out", 32'(sample_unsigned_out), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_clip_out", 32'(clip_out), 32'd0);
        check("rst_clip_count_out", 32'(clip_count_out), 32'd0);
      end
      last_out = '0;
    end else if (valid_out) begin
      if (sb.size() == 0) begin
        check("spurious_valid_out", 32'(valid_out), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sample_out", 32'($unsigned(sample_out)), 32'(e.sample));
        check("sample_unsigned_out", 32'(sample_unsigned_out),
              32'({~e.sample[15], e.sample[14:0]}));
        check("clip_out", 32'(clip_out), 32'(e.clip));
        check("clip_count_out", 32'(clip_count_out), 32'(e.cnt));
        check("latency", 32'(cyc - e.issue), 32'd3);
        last_out = sample_out;
      end
    end else begin
      check("hold_sample_out", 32'($unsigned(sample_out)), 32'(last_out));
      check("idle_clip_out", 32'(clip_out), 32'd0);
    end
  end

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; sample_in = '0; gain_in = '0; bypass_in = 1'b0;
    #2;
    rst_in    = 1'b0;
    chk_reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      valid_in  = ~valid_in;
      sample_in = 16'($urandom);
      gain_in   = 4'($urandom_range(15));
    end
    valid_in = 1'b0;
    @(negedge clk_in); #1;
    chk_reset = 1'b0;
    rst_in    = 1'b1;

    // DC removal of a constant +1000
    for (int i = 0; i < 2000; i++) send(16'd1000, 4'd0, 1'b0);
    idle();
    drain();
    n_cmp++;
    if ($signed(last_out) > 1 || $signed(last_out) < -1) begin
      n_fail++;
      $display("FAIL dc_residual: got %0d, expected within +/-1", $signed(last_out));
    end

    // Saturation both ways with acc at zero after warmup
    do_reset();
    for (int i = 0; i < 256; i++) send(16'h0000, 4'd0, 1'b0);
    send(16'h4000, 4'd2, 1'b0);
    send(16'hC000, 4'd2, 1'b0);
    idle();

    // Bypass of -5 with a gain that must be ignored
    send(16'hFFFB, 4'd3, 1'b1);
    idle(); idle();

    // Back-to-back bypass ramp
    for (int i = 1; i <= 10; i++) send(16'(i), 4'd0, 1'b1);
    idle();
    drain();

    // Randomized traffic with gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle();
      send(16'($urandom), 4'($urandom_range(15)), ($urandom_range(3) == 0));
    end
    idle();
    drain();

    // Reset with two samples in flight, then a fresh warmup
    send(16'h1234, 4'd1, 1'b0);
    send(16'h0042, 4'd0, 1'b1);
    do_reset();
    for (int i = 0; i < 256; i++) send(16'($urandom), 4'($urandom_range(15)), 1'b0);
    for (int i = 0; i < 20; i++) send(16'($urandom), 4'($urandom_range(15)), 1'b0);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
